// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: queues {write_data, pc} commit records and streams
// them as HDR-prefixed little-endian byte records, closing with a TERM byte.
module commit_trace_tx #(
  parameter int          DEPTH = 8,
  parameter logic [7:0]  HDR   = 8'hA5,
  parameter logic [7:0]  TERM  = 8'hEB
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_commit,
  input  logic [63:0] pc,
  input  logic [63:0] write_data,
  input  logic        cpu_ebreak_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        overflow,
  output logic [31:0] dropped_count,
  output logic        trace_done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_TERM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [127:0]  shreg;
  logic [4:0]    idx;
  logic          ebreak_pending;

  logic full;
  logic empty;
  logic pop;
  logic live_commit;
  logic push;
  logic drop;
  logic fire;

  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign pop         = (state == S_IDLE) && !empty;
  assign live_commit = inst_commit && !ebreak_pending;
  // A full FIFO still takes a commit when the head leaves in the same cycle.
  assign push        = live_commit && (!full || pop);
  assign drop        = live_commit && full && !pop;
  assign fire        = out_valid && out_ready;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    out_valid  = (state == S_SEND) || (state == S_TERM);
    trace_done = (state == S_DONE);
    out_data   = 8'h00;
    case (state)
      S_SEND:  out_data = (idx == 5'd0) ? HDR : shreg[7:0];
      S_TERM:  out_data = TERM;
      default: out_data = 8'h00;
    endcase
  end

  // NOTE: the record store has no reset; its contents are unreachable once the pointers and count clear.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {write_data, pc};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      shreg          <= '0;
      idx            <= '0;
      ebreak_pending <= 1'b0;
      overflow       <= 1'b0;
      dropped_count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (drop) begin
        overflow <= 1'b1;
        if (dropped_count != 32'hFFFF_FFFF) dropped_count <= dropped_count + 32'd1;
      end

      if (cpu_ebreak_sign) ebreak_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg <= mem[rd_ptr];
            idx   <= '0;
            state <= S_SEND;
          end else if (ebreak_pending) begin
            state <= S_TERM;
          end
        end
        S_SEND: begin
          if (fire) begin
            if (idx == 5'd16) begin
              state <= S_IDLE;
            end else begin
              idx <= idx + 5'd1;
              // Byte 0 is the header; payload bytes shift out from the low end.
              if (idx != 5'd0) shreg <= shreg >> 8;
            end
          end
        end
        S_TERM: begin
          if (fire) state <= S_DONE;
        end
        default: state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Self-checking bench for commit_trace_tx: literal vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_commit_trace_tx;

  localparam int         DEPTH = 8;
  localparam logic [7:0] HDR   = 8'hA5;
  localparam logic [7:0] TERM  = 8'hEB;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_commit;
  logic [63:0] pc;
  logic [63:0] write_data;
  logic        cpu_ebreak_sign;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        overflow;
  logic [31:0] dropped_count;
  logic        trace_done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  commit_trace_tx #(.DEPTH(DEPTH), .HDR(HDR), .TERM(TERM)) dut (
    .clock           (clock),
    .reset           (reset),
    .inst_commit     (inst_commit),
    .pc              (pc),
    .write_data      (write_data),
    .cpu_ebreak_sign (cpu_ebreak_sign),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .overflow        (overflow),
    .dropped_count   (dropped_count),
    .trace_done      (trace_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending records, the byte list of the record
  // being sent, and flags for terminator / closed trace.
  logic [127:0] mq[$];
  logic [7:0]   mcur[$];
  logic [7:0]   got[$];
  bit           m_send, m_term, m_done, m_pend, m_ovf;
  logic [31:0]  m_drop;
  bit           s_stall;
  logic [7:0]   s_data;

  task automatic model_reset();
    mq.delete();
    mcur.delete();
    got.delete();
    m_send = 0; m_term = 0; m_done = 0; m_pend = 0; m_ovf = 0;
    m_drop = '0;
    s_stall = 0;
    s_data = '0;
  endtask

  function automatic bit model_pop();
    return !m_send && !m_term && !m_done && (mq.size() > 0);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    inst_commit = 1'b0; pc = '0; write_data = '0; cpu_ebreak_sign = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", dropped_count, 0);
    check("rst_done", trace_done, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cycle(input logic c, input logic [63:0] p, input logic [63:0] w,
                       input logic e, input logic r);
    logic [7:0]   exp_data;
    logic         exp_valid;
    bit           pop, go_term, fire;
    logic [127:0] rec;
    @(negedge clock);
    inst_commit = c; pc = p; write_data = w; cpu_ebreak_sign = e; out_ready = r;
    #1;
    exp_valid = m_send || m_term;
    exp_data  = m_send ? mcur[0] : (m_term ? TERM : 8'h00);
    check("out_valid", out_valid, exp_valid);
    check("out_data", out_data, exp_data);
    check("trace_done", trace_done, m_done);
    check("overflow", overflow, m_ovf);
    check("dropped_count", dropped_count, m_drop);
    if (s_stall) check("stall_hold", out_data, s_data);
    s_stall = out_valid && !r;
    s_data  = out_data;
    if (out_valid && r) got.push_back(out_data);

    fire    = exp_valid && r;
    pop     = model_pop();
    go_term = !m_send && !m_term && !m_done && (mq.size() == 0) && m_pend;
    if (pop) begin
      rec = mq.pop_front();
      mcur.delete();
      mcur.push_back(HDR);
      for (int i = 0; i < 16; i++) mcur.push_back(rec[8*i +: 8]);
      m_send = 1;
    end else if (fire && m_send) begin
      void'(mcur.pop_front());
      if (mcur.size() == 0) m_send = 0;
    end
    if (c && !m_pend) begin
      if (mq.size() < DEPTH) mq.push_back({w, p});
      else begin
        m_ovf = 1;
        if (m_drop != 32'hFFFF_FFFF) m_drop++;
      end
    end
    if (fire && m_term) begin
      m_term = 0;
      m_done = 1;
    end
    if (go_term) m_term = 1;
    if (e) m_pend = 1;
  endtask

  typedef struct {
    logic       commit;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int n;
    bit hit;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h80};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h88};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h77};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h66};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h55};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 8'h44};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 8'h33};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 8'h22};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 8'h11};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 8'h00};

    // Single record, sink always ready: fixed latency and byte order.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      inst_commit = tbl[i].commit; pc = 64'h8000_0000; write_data = 64'h1122_3344_5566_7788;
      cpu_ebreak_sign = 1'b0; out_ready = tbl[i].ready;
      #1;
      check($sformatf("tbl_valid[%0d]", i), out_valid, tbl[i].exp_valid);
      check($sformatf("tbl_data[%0d]", i), out_data, tbl[i].exp_data);
    end

    // Same record under a 1,0,0,1 ready pattern.
    do_reset();
    for (int k = 0; k < 80; k++)
      cycle(k == 0, 64'h8000_0000, 64'h1122_3344_5566_7788, 1'b0, (k % 4 == 0) || (k % 4 == 3));
    check("bp_count", got.size(), 17);
    for (int i = 0; i < 17 && i < got.size(); i++)
      check($sformatf("bp_byte[%0d]", i), got[i], tbl[2+i].exp_data);

    // Ten commits with the sink stalled: the first record moves into the
    // serialiser on the first idle cycle, so nine are kept and one is dropped.
    do_reset();
    for (int k = 0; k < 10; k++)
      cycle(1'b1, 64'h1000 + 64'(k), 64'hD000 + 64'(k), 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("ovf_drop", dropped_count, 1);
    check("ovf_flag", overflow, 1);
    // Commit landing exactly on the idle pop of a full FIFO is accepted.
    hit = 0;
    for (int k = 0; k < 60 && !hit; k++) begin
      if (model_pop() && mq.size() == DEPTH) begin
        cycle(1'b1, 64'h2000, 64'hE000, 1'b0, 1'b1);
        hit = 1;
      end else cycle(1'b0, '0, '0, 1'b0, 1'b1);
    end
    check("full_pop_hit", hit, 1);
    check("full_pop_drop", dropped_count, 1);
    for (int k = 0; k < 400; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("ovf_bytes", got.size(), 10 * 17);
    if (got.size() >= 2) check("ovf_first_pc", got[1], 8'h00);
    if (got.size() >= 18) check("ovf_second_hdr", got[17], HDR);

    // Ebreak with a same-cycle commit, later commits ignored.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 64'h300 + 64'(k), 64'h4000 + 64'(k), 1'b0, 1'b1);
    cycle(1'b1, 64'h303, 64'h4003, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 64'h900 + 64'(k), 64'h9000, k == 1, 1'b1);
    n = 0;
    while (!m_done && n < 200) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      n++;
    end
    check("eb_bound", m_done, 1);
    for (int k = 0; k < 5; k++) cycle(1'b1, 64'h5, 64'h5, 1'b1, 1'b1);
    check("eb_bytes", got.size(), 4 * 17 + 1);
    if (got.size() == 69) check("eb_term", got[68], TERM);
    check("eb_done", trace_done, 1);
    check("eb_drop", dropped_count, 0);

    // Reset at byte 5 of a record with two more queued.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 64'h700 + 64'(k), 64'h7700 + 64'(k), 1'b0, 1'b0);
    n = 0;
    while (got.size() < 5 && n < 40) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      n++;
    end
    check("mid_bound", got.size(), 5);
    #2 reset = 1'b1;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_data", out_data, 0);
    check("mid_done", trace_done, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("mid_quiet", got.size(), 0);
    cycle(1'b1, 64'hABC, 64'hDEF, 1'b0, 1'b1);
    for (int k = 0; k < 25; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("mid_fresh_count", got.size(), 17);
    if (got.size() > 0) check("mid_fresh_hdr", got[0], HDR);

    // Randomized traffic, ebreak late, then drain to the closed trace.
    do_reset();
    for (int k = 0; k < 800; k++)
      cycle($urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom},
            k == 700, $urandom_range(0, 9) < 6);
    n = 0;
    while (!m_done && n < 1000) begin
      cycle($urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom},
            1'b0, $urandom_range(0, 9) < 6);
      n++;
    end
    check("rand_bound", m_done, 1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("rand_done", trace_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
